// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: arbitrates CPU word fetches against loader byte
// writes onto a single byte-wide memory port, assembling words over four beats.
module instr_fetch_ctrl #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_AW        = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_req,
   input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
   output logic                     fetch_ready,
   output logic                     fetch_valid,
   output logic [31:0]              fetch_data,
   input  logic                     load_req,
   input  logic [ADDRESS_WIDTH-1:0] load_addr,
   input  logic [7:0]               load_data,
   output logic                     load_ack,
   output logic [MEM_AW-1:0]        mem_addr,
   output logic                     mem_we,
   output logic [7:0]               mem_wdata,
   input  logic [7:0]               mem_rdata
);

   // state  | meaning
   // S_IDLE | arbitrate; loader writes complete here in one cycle
   // S_READ | beat_q selects the byte being read and captured
   // S_DONE | fetch_valid pulse, then back to S_IDLE
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        beat_q, beat_d;
   logic [MEM_AW-1:0] base_q, base_d;
   logic [31:0]       data_q, data_d;
   logic              rr_fetch_q, rr_fetch_d;
   logic              grant_fetch, grant_load;

   // Only the low MEM_AW address bits reach the array.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{fetch_addr[ADDRESS_WIDTH-1:MEM_AW], load_addr[ADDRESS_WIDTH-1:MEM_AW]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         beat_q     <= 2'd0;
         base_q     <= '0;
         data_q     <= 32'd0;
         rr_fetch_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         base_q     <= base_d;
         data_q     <= data_d;
         rr_fetch_q <= rr_fetch_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      base_d      = base_q;
      data_d      = data_q;
      rr_fetch_d  = rr_fetch_q;
      grant_fetch = 1'b0;
      grant_load  = 1'b0;
      fetch_ready = 1'b0;
      fetch_valid = 1'b0;
      load_ack    = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = 8'd0;

      case (state_q)
         S_IDLE: begin
            // Reset gates the grants so no write can slip out during a reset cycle.
            if (!rst) begin
               grant_fetch = fetch_req && (!load_req || rr_fetch_q);
               grant_load  = load_req && !grant_fetch;
               if (fetch_req && load_req) begin
                  rr_fetch_d = !grant_fetch;
               end
            end
            if (grant_load) begin
               mem_we    = 1'b1;
               mem_addr  = load_addr[MEM_AW-1:0];
               mem_wdata = load_data;
               load_ack  = 1'b1;
            end
            if (grant_fetch) begin
               fetch_ready = 1'b1;
               base_d      = fetch_addr[MEM_AW-1:0];
               beat_d      = 2'd0;
               state_d     = S_READ;
            end
         end
         S_READ: begin
            mem_addr = base_q + {{(MEM_AW-2){1'b0}}, beat_q};
            data_d[{beat_q, 3'b000} +: 8] = mem_rdata;
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            fetch_valid = !rst;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign fetch_data = data_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed and randomized loads/fetches checked
// against a byte-array memory model and a round-robin fairness model.
module tb_instr_fetch_ctrl;

   localparam int AW    = 32;
   localparam int MAW   = 12;
   localparam int MSIZE = 4096;

   logic          clk = 1'b0;
   logic          rst;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_ready;
   logic          fetch_valid;
   logic [31:0]   fetch_data;
   logic          load_req;
   logic [AW-1:0] load_addr;
   logic [7:0]    load_data;
   logic          load_ack;
   logic [MAW-1:0] mem_addr;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   logic [7:0] mem     [0:MSIZE-1];
   logic [7:0] ref_mem [0:MSIZE-1];

   int n_checks = 0;
   int n_pass   = 0;
   bit fetch_wins_next;

   instr_fetch_ctrl #(.ADDRESS_WIDTH(AW), .MEM_AW(MAW)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data),
      .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_word(input int base);
      return {ref_mem[(base + 3) % MSIZE], ref_mem[(base + 2) % MSIZE],
              ref_mem[(base + 1) % MSIZE], ref_mem[base % MSIZE]};
   endfunction

   task automatic idle_cycle();
      @(negedge clk);
      fetch_req = 1'b0;
      load_req  = 1'b0;
      #1;
      check("idle_addr", 32'(mem_addr), 32'd0);
      check("idle_we", 32'(mem_we), 32'd0);
      check("idle_wdata", 32'(mem_wdata), 32'd0);
   endtask

   task automatic do_load(input logic [31:0] a, input logic [7:0] d);
      @(negedge clk);
      fetch_req = 1'b0;
      load_req  = 1'b1;
      load_addr = a;
      load_data = d;
      #1;
      check("load_ack", 32'(load_ack), 32'd1);
      check("load_we", 32'(mem_we), 32'd1);
      check("load_addr", 32'(mem_addr), a % MSIZE);
      check("load_wdata", 32'(mem_wdata), 32'(d));
      ref_mem[a % MSIZE] = d;
      idle_cycle();
   endtask

   // Beats after acceptance; a held load_req must stay unacknowledged throughout.
   task automatic fetch_beats(input int base, output logic [31:0] word);
      logic [31:0] exp;
      exp = exp_word(base);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         fetch_req = 1'b0;
         #1;
         check("beat_addr", 32'(mem_addr), 32'((base + k) % MSIZE));
         check("beat_we", 32'(mem_we), 32'd0);
         check("beat_ack", 32'(load_ack) | 32'(fetch_ready), 32'd0);
         check("beat_valid", 32'(fetch_valid), 32'd0);
      end
      @(negedge clk);
      #1;
      check("done_valid", 32'(fetch_valid), 32'd1);
      check("done_data", fetch_data, exp);
      check("done_ack", 32'(load_ack) | 32'(mem_we), 32'd0);
      word = fetch_data;
      @(negedge clk);
      fetch_req = 1'b0;
      #1;
      check("post_valid", 32'(fetch_valid), 32'd0);
      check("post_hold", fetch_data, exp);
   endtask

   task automatic do_fetch(input logic [31:0] a, output logic [31:0] word);
      @(negedge clk);
      load_req   = 1'b0;
      fetch_req  = 1'b1;
      fetch_addr = a;
      #1;
      check("fetch_ready", 32'(fetch_ready), 32'd1);
      check("fetch_no_we", 32'(mem_we), 32'd0);
      fetch_beats(int'(a % MSIZE), word);
      load_req = 1'b0;
   endtask

   task automatic do_contest(input logic [31:0] fa, input logic [31:0] la, input logic [7:0] ld);
      logic [31:0] word;
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = fa;
      load_req   = 1'b1;
      load_addr  = la;
      load_data  = ld;
      #1;
      if (fetch_wins_next) begin
         check("ct_ready", 32'(fetch_ready), 32'd1);
         check("ct_ack", 32'(load_ack), 32'd0);
         check("ct_we", 32'(mem_we), 32'd0);
         fetch_wins_next = 1'b0;
         fetch_beats(int'(fa % MSIZE), word);
         load_req = 1'b1;
         #1;
         check("late_ack", 32'(load_ack), 32'd1);
         check("late_addr", 32'(mem_addr), la % MSIZE);
         ref_mem[la % MSIZE] = ld;
      end else begin
         check("ct_ack", 32'(load_ack), 32'd1);
         check("ct_we", 32'(mem_we), 32'd1);
         check("ct_ready", 32'(fetch_ready), 32'd0);
         check("ct_addr", 32'(mem_addr), la % MSIZE);
         ref_mem[la % MSIZE] = ld;
         fetch_wins_next = 1'b1;
      end
      idle_cycle();
   endtask

   initial begin
      logic [31:0] word;
      logic [31:0] a;
      logic [7:0]  v;

      rst = 1'b1;
      fetch_req = 1'b0; fetch_addr = '0;
      load_req = 1'b0;  load_addr = '0; load_data = 8'd0;
      for (int i = 0; i < MSIZE; i++) begin
         v = 8'($urandom);
         mem[i] <= v;
         ref_mem[i] = v;
      end
      fetch_wins_next = 1'b1;

      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", 32'(fetch_valid), 32'd0);
      check("rst_data", fetch_data, 32'd0);
      check("rst_ready", 32'(fetch_ready), 32'd0);
      load_req = 1'b1; load_addr = 32'h20; load_data = 8'h5A;
      #1;
      check("rst_ack", 32'(load_ack), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      load_req = 1'b0;

      do_load(32'h0, 8'h13);
      do_load(32'h1, 8'h00);
      do_load(32'h2, 8'h50);
      do_load(32'h3, 8'h00);
      do_fetch(32'h0, word);
      check("word_0", word, 32'h00500013);

      do_contest(32'h0000_0040, 32'h0000_0044, 8'hC3);
      do_contest(32'h0000_0040, 32'h0000_0045, 8'h3C);

      do_load(32'h010, 8'hAB);
      do_fetch(32'h010, word);
      check("word_010_b0", 32'(word[7:0]), 32'h000000AB);

      do_fetch(32'h0000_0FFE, word);
      do_fetch(32'h8000_1004, word);

      for (int it = 0; it < 40; it++) begin
         a = $urandom;
         a[11:0] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(4088, 4095))
                                               : 12'($urandom_range(0, 40));
         case ($urandom_range(0, 2))
            0: do_load(a, 8'($urandom));
            1: do_fetch(a, word);
            default: do_contest(a, {$urandom, 12'($urandom_range(0, 40))} >> 0, 8'($urandom));
         endcase
      end

      // Reset during READ beat 2, with a loader request pending.
      @(negedge clk);
      fetch_req = 1'b1; fetch_addr = 32'h8; load_req = 1'b0;
      @(negedge clk);
      fetch_req = 1'b0; load_req = 1'b1; load_addr = 32'h30; load_data = 8'h77;
      @(negedge clk);
      #1;
      check("rd_ack", 32'(load_ack), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rrst_we", 32'(mem_we), 32'd0);
      check("rrst_valid", 32'(fetch_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_data", fetch_data, 32'd0);
      check("arst_valid", 32'(fetch_valid), 32'd0);
      check("arst_ack", 32'(load_ack), 32'd1);
      ref_mem[32'h30] = 8'h77;
      fetch_wins_next = 1'b1;
      for (int k = 0; k < 3; k++) begin
         idle_cycle();
         check("arst_novalid", 32'(fetch_valid), 32'd0);
      end

      do_contest(32'h30, 32'h50, 8'h11);
      do_contest(32'h2E, 32'h51, 8'h22);
      do_fetch(32'h4E, word);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, fetch/load address width.
REQ-002 SHALL have parameter MEM_AW, default 12, byte-address width of the instruction memory array.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fetch_req  input  1  CPU requests a 32-bit instruction word.
REQ-006 SHALL have port fetch_addr  input  ADDRESS_WIDTH  byte address of the requested word.
REQ-007 SHALL have port fetch_ready  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port fetch_valid  output  1  fetch_data valid; one-cycle pulse.
REQ-009 SHALL have port fetch_data  output  32  assembled little-endian instruction word.
REQ-010 SHALL have port load_req  input  1  program loader requests a one-byte write.
REQ-011 SHALL have port load_addr  input  ADDRESS_WIDTH  loader byte address.
REQ-012 SHALL have port load_data  input  8  loader write byte.
REQ-013 SHALL have port load_ack  output  1  loader write performed this cycle.
REQ-014 SHALL have port mem_addr  output  MEM_AW  byte address to the memory array.
REQ-015 SHALL have port mem_we  output  1  byte write enable to the memory array.
REQ-016 SHALL have port mem_wdata  output  8  write byte to the memory array.
REQ-017 SHALL have port mem_rdata  input  8  combinational (same-cycle) read byte from the memory array.

Function
REQ-018 SHALL implement states IDLE, READ, DONE; READ has a 2-bit beat counter 0..3.
REQ-019 SHALL, in IDLE, arbitrate fetch_req against load_req: a sole requester wins; if both, grant the requester that did not win the last contested grant (round-robin flag updated only on contested cycles).
REQ-020 SHALL, on a load grant in IDLE, combinationally drive mem_we=1, mem_addr=load_addr[MEM_AW-1:0], mem_wdata=load_data, load_ack=1 for that cycle, and remain in IDLE.
REQ-021 SHALL, on a fetch grant in IDLE, drive fetch_ready=1 that cycle, latch fetch_addr[MEM_AW-1:0] as base, and enter READ with beat 0.
REQ-022 SHALL, in READ beat k, drive mem_addr=(base+k) mod 2**MEM_AW, mem_we=0, and capture mem_rdata into fetch_data[8k+7:8k] at the clock edge.
REQ-023 SHALL move READ beat 3 to DONE; in DONE, assert fetch_valid=1 for exactly one cycle, then return to IDLE.
REQ-024 SHALL give fetch latency of 5 cycles: acceptance edge, 4 READ cycles, fetch_valid during cycle 5.
REQ-025 SHALL hold fetch_data stable from DONE until the next capture; no bytes are cleared between fetches.
REQ-026 SHALL wrap byte addresses at 2**MEM_AW (base 0xFFE reads 0xFFE,0xFFF,0x000,0x001); upper address bits are ignored; misaligned bases are legal.
REQ-027 SHALL deassert fetch_ready and load_ack in READ and DONE; requests arriving then wait (no queuing beyond the requester holding req).
REQ-028 SHALL drive mem_addr=0, mem_we=0, mem_wdata=0 when no access occurs.

Reset
REQ-029 SHALL, with rst high at a clock edge, enter IDLE, clear the beat counter, fetch_valid=0, fetch_data=0, and set the round-robin flag so fetch wins the first contested grant.
REQ-030 SHALL abort an in-progress READ or DONE on reset with no fetch_valid pulse and no memory write; rst has priority over all requests.

Verification
REQ-031 Memory bytes 0x00..0x03 = 13,00,50,00; fetch_addr=0 -> fetch_ready cycle 0, mem_addr 0,1,2,3 cycles 1-4, fetch_valid cycle 5 with fetch_data=0x00500013.
REQ-032 fetch_req and load_req both high in IDLE after reset -> fetch granted first; next contested IDLE cycle -> load granted (load_ack=1, mem_we=1).
REQ-033 load_req addr=0x010 data=0xAB alone -> same-cycle mem_we=1, mem_addr=0x010, load_ack=1; subsequent fetch of 0x010 returns byte 0 = 0xAB.
REQ-034 fetch_addr=0x00000FFE -> mem_addr sequence 0xFFE,0xFFF,0x000,0x001; fetch_addr=0x80001004 -> base 0x004.
REQ-035 rst asserted during READ beat 2 -> next cycle IDLE, no fetch_valid, fetch_data=0; load_req during READ -> load_ack only after return to IDLE.
